// File: rtl/rtc_init_sequencer_if.sv
// Interface between the RTC init sequencer and its environment (top-level control FSM
// on the start/status side, read/write cycle generator on the bus side).
//   master : the sequencer (drives Req_I/Op_I/Addr_I/Data_I and status outputs)
//   slave  : the environment (drives Inicio_I, Final_WR, Rd_Data)
// Signals:
//   Inicio_I  start level          Final_WR  bus cycle complete pulse
//   Rd_Data   read-back data       Req_I     request strobe
//   Op_I      1=write, 0=read      Addr_I    register address
//   Data_I    write data           Busy_I    sequence in progress
//   Fin_I     sequence ended       Err_I     timeout / verify error
//   Idx_I     current entry index
interface rtc_init_sequencer_if #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4
);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic              Inicio_I;
    logic              Final_WR;
    logic [DATA_W-1:0] Rd_Data;
    logic              Req_I;
    logic              Op_I;
    logic [ADDR_W-1:0] Addr_I;
    logic [DATA_W-1:0] Data_I;
    logic              Busy_I;
    logic              Fin_I;
    logic              Err_I;
    logic [IDX_W-1:0]  Idx_I;

    modport master (
        input  Inicio_I, Final_WR, Rd_Data,
        output Req_I, Op_I, Addr_I, Data_I, Busy_I, Fin_I, Err_I, Idx_I
    );

    modport slave (
        output Inicio_I, Final_WR, Rd_Data,
        input  Req_I, Op_I, Addr_I, Data_I, Busy_I, Fin_I, Err_I, Idx_I
    );
endinterface

// File: rtl/rtc_init_sequencer.sv
// RTC init sequencer: on Inicio_I walks INIT_TABLE and issues one write request per
// {address,data} entry to the bus-cycle controller, handshaking on Final_WR, with a
// per-request timeout and error reporting.
// Optional feature: define INIT_VERIFY_EN to read back each register after its write
// and flag an error on mismatch.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    rtc_init_sequencer_if.master (start/status and cycle-generator signals)
module rtc_init_sequencer #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = 48'h200_1D2_000_210
) (
    input  logic                       clk,
    input  logic                       reset,
    rtc_init_sequencer_if.master       bus
);
    localparam int unsigned EW    = ADDR_W + DATA_W;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [3:0] {
        StIdle, StLoad, StReq, StWait, StNext, StDone, StErr, StRdReq, StRdWait, StCheck
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              op_q, op_d;
    logic [EW-1:0]     entry;
    logic              timeout_hit;
    logic              last_entry;

    assign entry       = INIT_TABLE[int'(idx_q)*EW +: EW];
    assign last_entry  = (idx_q == IDX_W'(NUM_REGS - 1));
    // TIMEOUT_CYC == 0 disables the timeout entirely.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef INIT_VERIFY_EN
    logic [DATA_W-1:0] rd_q, rd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_q <= '0;
        else        rd_q <= rd_d;
    end
`else
    logic unused_rd_data;
    assign unused_rd_data = ^bus.Rd_Data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
`ifdef INIT_VERIFY_EN
        rd_d    = rd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.Inicio_I) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                addr_d  = entry[EW-1 -: ADDR_W];
                data_d  = entry[DATA_W-1:0];
                op_d    = 1'b1;
                state_d = StReq;
            end
            StReq: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Final_WR takes priority over a timeout in the same cycle.
                if (bus.Final_WR) begin
`ifdef INIT_VERIFY_EN
                    op_d    = 1'b0;
                    state_d = StRdReq;
`else
                    state_d = StNext;
`endif
                end else if (timeout_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StNext: begin
                if (last_entry) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StLoad;
                end
            end
            StDone, StErr: begin
                if (!bus.Inicio_I) state_d = StIdle;
            end
`ifdef INIT_VERIFY_EN
            StRdReq: begin
                cnt_d   = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (bus.Final_WR) begin
                    rd_d    = bus.Rd_Data;
                    state_d = StCheck;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCheck: begin
                state_d = (rd_q == data_q) ? StNext : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign bus.Req_I  = (state_q == StReq) || (state_q == StRdReq);
    assign bus.Op_I   = op_q;
    assign bus.Addr_I = addr_q;
    assign bus.Data_I = data_q;
    assign bus.Busy_I = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign bus.Fin_I  = (state_q == StDone) || (state_q == StErr);
    assign bus.Err_I  = (state_q == StErr);
    assign bus.Idx_I  = idx_q;
endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Self-checking bench for rtc_init_sequencer (default table, TIMEOUT_CYC=16).
// Build with INIT_VERIFY_EN defined to also exercise read-back verify.
module tb_rtc_init_sequencer;
    localparam int TO = 16;
`ifdef INIT_VERIFY_EN
    localparam int NREQ = 8;
`else
    localparam int NREQ = 4;
`endif

    typedef struct {
        int         fin_delay;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   req_cnt;
    vec_t vec [4];

    rtc_init_sequencer_if #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(4)) bus ();

    rtc_init_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (bus.Req_I === 1'b1) req_cnt = req_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_event required=event", name);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (bus.Req_I === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) bound_fail("wait_req");
    endtask

    task automatic wait_fin(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (bus.Fin_I === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) bound_fail("wait_fin");
    endtask

    task automatic pulse_final(input int delay, input logic [7:0] rd);
        repeat (delay) @(negedge clk);
        bus.Final_WR = 1'b1;
        bus.Rd_Data  = rd;
        @(negedge clk);
        bus.Final_WR = 1'b0;
        bus.Rd_Data  = 8'h00;
    endtask

    // Serve one entry: check the write request, complete it, then (verify build) the read.
    task automatic serve_entry(input int i, input logic [7:0] rd_val, input bit drop,
                               output bit ok);
        wait_req(ok);
        if (!ok) return;
        chk("wr_addr", bus.Addr_I, vec[i].addr);
        chk("wr_data", bus.Data_I, vec[i].data);
        chk("wr_op", bus.Op_I, 1);
        chk("wr_busy", bus.Busy_I, 1);
        if (drop) bus.Inicio_I = 1'b0;
        pulse_final(vec[i].fin_delay, 8'h00);
`ifdef INIT_VERIFY_EN
        wait_req(ok);
        if (!ok) return;
        chk("rd_op", bus.Op_I, 0);
        chk("rd_addr", bus.Addr_I, vec[i].addr);
        pulse_final(vec[i].fin_delay, rd_val);
`else
        if (rd_val != 8'h00) ;
`endif
    endtask

    task automatic run_seq(input bit drop_early, input int bad, input logic [7:0] bad_val,
                           input int exp_reqs);
        bit ok;
        int base;
        int stop_at;
        logic [7:0] rd;
        base    = req_cnt;
        stop_at = (bad >= 0) ? bad : 3;
        bus.Inicio_I = 1'b1;
        for (int i = 0; i <= stop_at; i++) begin
            rd = (i == bad) ? bad_val : vec[i].data;
            serve_entry(i, rd, drop_early && (i == 0), ok);
            if (!ok) return;
        end
        wait_fin(ok);
        if (!ok) return;
        chk("fin", bus.Fin_I, 1);
        chk("err", bus.Err_I, (bad >= 0) ? 1 : 0);
        chk("end_busy", bus.Busy_I, 0);
        chk("end_idx", bus.Idx_I, (bad >= 0) ? bad : 3);
        chk("req_count", req_cnt - base, exp_reqs);
        if (!drop_early) begin
            @(negedge clk);
            chk("done_hold", bus.Fin_I, 1);
        end
        bus.Inicio_I = 1'b0;
        @(negedge clk);
        chk("fin_clear", bus.Fin_I, 0);
        chk("idle_busy", bus.Busy_I, 0);
    endtask

    initial begin
        bit ok;
        int n;
        int base;
        checks   = 0;
        failures = 0;
        req_cnt  = 0;
        vec[0] = '{2, 4'h2, 8'h10};
        vec[1] = '{2, 4'h0, 8'h00};
        vec[2] = '{2, 4'h1, 8'hD2};
        vec[3] = '{2, 4'h2, 8'h00};

        reset        = 1'b0;
        bus.Inicio_I = 1'b0;
        bus.Final_WR = 1'b0;
        bus.Rd_Data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.Req_I, 0);
        chk("rst_op", bus.Op_I, 0);
        chk("rst_addr", bus.Addr_I, 0);
        chk("rst_data", bus.Data_I, 0);
        chk("rst_busy", bus.Busy_I, 0);
        chk("rst_fin", bus.Fin_I, 0);
        chk("rst_err", bus.Err_I, 0);
        chk("rst_idx", bus.Idx_I, 0);
        reset = 1'b1;
        @(negedge clk);

        // Final_WR in IDLE is ignored.
        bus.Final_WR = 1'b1;
        @(negedge clk);
        bus.Final_WR = 1'b0;
        @(negedge clk);
        chk("idle_fwr_busy", bus.Busy_I, 0);
        chk("idle_fwr_fin", bus.Fin_I, 0);
        chk("idle_fwr_req", bus.Req_I, 0);

        // Normal sequence, then with Inicio_I dropped after the first request.
        run_seq(1'b0, -1, 8'h00, NREQ);
        run_seq(1'b1, -1, 8'h00, NREQ);

        // Final_WR on the last allowed WAIT cycle, and on the first.
        vec[0].fin_delay = TO;
        vec[3].fin_delay = 1;
        run_seq(1'b0, -1, 8'h00, NREQ);
        vec[0].fin_delay = 2;
        vec[3].fin_delay = 2;

        // Timeout: Final_WR never arrives.
        base = req_cnt;
        bus.Inicio_I = 1'b1;
        wait_req(ok);
        if (ok) begin
            n = 0;
            while (bus.Fin_I !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("to_cycles", n, TO + 1);
            chk("to_err", bus.Err_I, 1);
            chk("to_idx", bus.Idx_I, 0);
            chk("to_reqs", req_cnt - base, 1);
            bus.Inicio_I = 1'b0;
            @(negedge clk);
            chk("to_fin_clear", bus.Fin_I, 0);
        end

        // Asynchronous reset during WAIT of entry 2.
        bus.Inicio_I = 1'b1;
        serve_entry(0, vec[0].data, 1'b0, ok);
        if (ok) serve_entry(1, vec[1].data, 1'b0, ok);
        if (ok) wait_req(ok);
        if (ok) begin
            @(negedge clk);
            #2;
            reset        = 1'b0;
            bus.Inicio_I = 1'b0;
            #1;
            chk("ar_busy", bus.Busy_I, 0);
            chk("ar_addr", bus.Addr_I, 0);
            chk("ar_data", bus.Data_I, 0);
            chk("ar_op", bus.Op_I, 0);
            chk("ar_idx", bus.Idx_I, 0);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            run_seq(1'b0, -1, 8'h00, NREQ);
        end

`ifdef INIT_VERIFY_EN
        // Read-back mismatch on entry 2.
        run_seq(1'b0, 2, 8'hD3, 6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
